// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_reg_chain pipeline register family.
package pipe_pkg;

  localparam int unsigned PIPE_RESET_VAL = 0;

  // Width needed to count 0..depth valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One data/valid register pair of the pipeline; loads from upstream when advanced.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_RESET_VAL)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             adv,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             v_next,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  assign v_next = flush ? 1'b0 : (adv ? up_valid : v);

  // Bubbles do not load data, so a collapsing stage keeps its old word and saves toggles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else begin
      v <= v_next;
      if (flush)
        d <= RESET_VAL;
      else if (adv && up_valid)
        d <= up_data;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready pipeline register with bubble collapse, flush and occupancy count.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_RESET_VAL)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] up_valid;
  logic [WIDTH-1:0] up_data [DEPTH];
  logic [WIDTH-1:0] d       [DEPTH];
  logic [OCC_W-1:0] occ_next;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // Unrolled form of adv[i] = !v[i] | adv[i+1]: a stage advances unless it and every later stage are full and stalled.
    assign adv[i] = out_ready || !(&v[DEPTH-1:i]);

    if (i == 0) begin : g_head
      assign up_valid[i] = in_valid & in_ready;
      assign up_data[i]  = in_data;
    end else begin : g_body
      assign up_valid[i] = v[i-1];
      assign up_data[i]  = d[i-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .adv      (adv[i]),
      .up_valid (up_valid[i]),
      .up_data  (up_data[i]),
      .v_next   (v_next[i]),
      .v        (v[i]),
      .d        (d[i])
    );
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_comb begin
    occ_next = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      occ_next = occ_next + OCC_W'(v_next[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      occupancy <= '0;
    else
      occupancy <= occ_next;
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: directed DEPTH=3 cases plus random DEPTH=1/5 streams.
module tb_pipe_reg_chain;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        fl3, iv3, or3, ir3, ov3;
  logic [7:0]  id3, od3;
  logic [1:0]  oc3;
  logic        fl1, iv1, or1, ir1, ov1;
  logic [15:0] id1, od1;
  logic [0:0]  oc1;
  logic        fl5, iv5, or5, ir5, ov5;
  logic [15:0] id5, od5;
  logic [2:0]  oc5;

  pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hC3)) u3 (
    .clk(clk), .reset_n(reset_n), .flush(fl3), .in_valid(iv3), .in_data(id3),
    .in_ready(ir3), .out_valid(ov3), .out_data(od3), .out_ready(or3), .occupancy(oc3));
  pipe_reg_chain #(.WIDTH(16), .DEPTH(1)) u1 (
    .clk(clk), .reset_n(reset_n), .flush(fl1), .in_valid(iv1), .in_data(id1),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_ready(or1), .occupancy(oc1));
  pipe_reg_chain #(.WIDTH(16), .DEPTH(5)) u5 (
    .clk(clk), .reset_n(reset_n), .flush(fl5), .in_valid(iv5), .in_data(id5),
    .in_ready(ir5), .out_valid(ov5), .out_data(od5), .out_ready(or5), .occupancy(oc5));

  logic [31:0] sq [3][$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Words in flight equal valid stages, so the queue size is the expected occupancy.
  task automatic mon(input int id, input int unsigned depth, input logic fl, input logic iv,
                     input logic ir, input logic ov, input logic ordy,
                     input logic [31:0] idat, input logic [31:0] odat, input logic [31:0] occ);
    string p;
    logic [31:0] exp;
    p = $sformatf("u%0d", depth);
    if (!reset_n) begin
      sq[id].delete();
      return;
    end
    check({p, "_occ"}, occ, sq[id].size());
    check({p, "_in_ready"}, {31'd0, ir}, {31'd0, !fl && !(sq[id].size() == depth && !ordy)});
    if (ov && ordy) begin
      if (sq[id].size() == 0) check({p, "_out_valid_empty"}, {31'd0, ov}, 32'd0);
      else begin
        exp = sq[id].pop_front();
        check({p, "_out_data"}, odat, exp);
      end
    end
    if (fl) sq[id].delete();
    if (iv && ir) sq[id].push_back(idat);
  endtask

  always @(negedge clk) begin
    mon(0, 3, fl3, iv3, ir3, ov3, or3, 32'(id3), 32'(od3), 32'(oc3));
    mon(1, 1, fl1, iv1, ir1, ov1, or1, 32'(id1), 32'(od1), 32'(oc1));
    mon(2, 5, fl5, iv5, ir5, ov5, or5, 32'(id5), 32'(od5), 32'(oc5));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {fl3, iv3, or3, id3} = '0;
    {fl1, iv1, or1, id1} = '0;
    {fl5, iv5, or5, id5} = '0;

    #12;
    check("rst_ov3", {31'd0, ov3}, 32'd0);
    check("rst_oc3", 32'(oc3), 32'd0);
    check("rst_od3", 32'(od3), 32'hC3);
    check("rst_ov5", {31'd0, ov5}, 32'd0);
    check("rst_od5", 32'(od5), 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    #1 check("rst_ir3", {31'd0, ir3}, 32'd1);
    step();

    // Latency and back-to-back streaming
    iv3 = 1'b1; id3 = 8'h11; or3 = 1'b1;
    step(); id3 = 8'h22; check("lat_e0", {31'd0, ov3}, 32'd0);
    step(); id3 = 8'h33; check("lat_e1", {31'd0, ov3}, 32'd0);
    step(); iv3 = 1'b0;
    check("lat_ov", {31'd0, ov3}, 32'd1);
    check("lat_11", 32'(od3), 32'h11);
    step(); check("b2b_22", 32'(od3), 32'h22);
    step(); check("b2b_33", 32'(od3), 32'h33);
    step(); check("b2b_empty", {31'd0, ov3}, 32'd0);

    // Fill under backpressure
    or3 = 1'b0; iv3 = 1'b1; id3 = 8'h01;
    step(); id3 = 8'h02;
    step(); id3 = 8'h03;
    step(); id3 = 8'h04;
    check("full_ir", {31'd0, ir3}, 32'd0);
    check("full_occ", 32'(oc3), 32'd3);
    step();
    check("hold_occ", 32'(oc3), 32'd3);
    check("hold_od", 32'(od3), 32'h01);
    or3 = 1'b1;
    #1 check("full_ir_drain", {31'd0, ir3}, 32'd1);
    step(); iv3 = 1'b0;
    check("full_occ_keep", 32'(oc3), 32'd3);
    check("ord_2", 32'(od3), 32'h02);
    step(); check("ord_3", 32'(od3), 32'h03);
    step(); check("ord_4", 32'(od3), 32'h04);
    step(); check("ord_empty", {31'd0, ov3}, 32'd0);

    // Bubble collapse
    or3 = 1'b0; iv3 = 1'b1; id3 = 8'hA5;
    step(); iv3 = 1'b0;
    step(); iv3 = 1'b1; id3 = 8'h5B;
    step(); iv3 = 1'b0;
    step();
    step();
    check("bub_occ", 32'(oc3), 32'd2);
    check("bub_ir", {31'd0, ir3}, 32'd1);
    check("bub_A", 32'(od3), 32'hA5);
    or3 = 1'b1;
    step(); check("bub_B_packed", 32'(od3), 32'h5B);
    check("bub_B_valid", {31'd0, ov3}, 32'd1);
    step(); check("bub_empty", {31'd0, ov3}, 32'd0);

    // Flush while full with an output handshake
    or3 = 1'b0; iv3 = 1'b1; id3 = 8'h61;
    step(); id3 = 8'h62;
    step(); id3 = 8'h63;
    step();
    fl3 = 1'b1; id3 = 8'h77; or3 = 1'b1;
    #1 check("fl_ir", {31'd0, ir3}, 32'd0);
    check("fl_occ_pre", 32'(oc3), 32'd3);
    step(); fl3 = 1'b0; iv3 = 1'b0; or3 = 1'b0;
    check("fl_occ", 32'(oc3), 32'd0);
    check("fl_ov", {31'd0, ov3}, 32'd0);
    check("fl_od", 32'(od3), 32'hC3);

    // Asynchronous reset between edges
    iv3 = 1'b1; id3 = 8'h91;
    step(); id3 = 8'h92;
    step(); iv3 = 1'b0;
    step();
    check("ar_pre_ov", {31'd0, ov3}, 32'd1);
    check("ar_pre_occ", 32'(oc3), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check("ar_ov", {31'd0, ov3}, 32'd0);
    check("ar_occ", 32'(oc3), 32'd0);
    check("ar_od", 32'(od3), 32'hC3);
    @(negedge clk);
    #1 reset_n = 1'b1;
    step();

    // Random traffic
    repeat (1000) begin
      iv1 = 1'($urandom_range(0, 1)); id1 = 16'($urandom); or1 = 1'($urandom_range(0, 1));
      iv5 = 1'($urandom_range(0, 1)); id5 = 16'($urandom); or5 = 1'($urandom_range(0, 1));
      iv3 = 1'($urandom_range(0, 1)); id3 = 8'($urandom);  or3 = 1'($urandom_range(0, 1));
      fl3 = ($urandom_range(0, 31) == 0);
      step();
    end
    {iv1, iv3, iv5, fl3} = '0;
    {or1, or3, or5} = 3'b111;
    repeat (8) step();
    check("drain_q1", sq[1].size(), 32'd0);
    check("drain_q5", sq[2].size(), 32'd0);
    check("drain_q3", sq[0].size(), 32'd0);
    check("drain_ov5", {31'd0, ov5}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
